// File: rtl/topk_frame_drain.sv
// Frame top-K collector: keeps the K largest unsigned samples of a frame sorted, then drains them largest-first.
// Optional TOPK_DEDUP_EN: samples equal to a held entry are dropped so drained values are strictly descending.
module topk_frame_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [$clog2(K)-1:0]  out_rank
);

  localparam int CW = $clog2(K + 1);
  localparam int IW = $clog2(K);

  typedef enum logic {ST_COLLECT, ST_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_entry [K];
  logic [DATA_WIDTH-1:0] w_ins_bank [K];
  logic [CW-1:0]         r_fill;
  logic [CW-1:0]         r_rd_idx;
  logic [CW-1:0]         w_pos;
  logic                  w_found;
  logic                  w_dup;
  logic                  w_ins;
  logic                  w_in_acc;
  logic                  w_out_xfer;
  logic                  w_last_rank;

  // Bank is sorted, so the first filled entry below in_data is the insertion slot.
  always_comb begin
    w_found = 1'b0;
    w_pos   = r_fill;
    w_dup   = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (!w_found && (CW'(i) < r_fill) && (r_entry[i] < in_data)) begin
        w_found = 1'b1;
        w_pos   = CW'(i);
      end
    end
`ifdef TOPK_DEDUP_EN
    for (int i = 0; i < K; i++) begin
      if ((CW'(i) < r_fill) && (r_entry[i] == in_data)) begin
        w_dup = 1'b1;
      end
    end
`endif
    w_ins = (w_found || (r_fill < CW'(K))) && !w_dup;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) < w_pos) begin
        w_ins_bank[i] = r_entry[i];
      end else if (CW'(i) == w_pos) begin
        w_ins_bank[i] = in_data;
      end else if (i > 0) begin
        w_ins_bank[i] = r_entry[i-1];
      end else begin
        w_ins_bank[i] = r_entry[i];
      end
    end
  end

  assign w_in_acc    = in_valid && (r_state == ST_COLLECT);
  assign w_out_xfer  = out_ready && (r_state == ST_DRAIN);
  assign w_last_rank = ((r_rd_idx + CW'(1)) == r_fill);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_in_acc && in_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_out_xfer && w_last_rank) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fill   <= '0;
      r_rd_idx <= '0;
      for (int i = 0; i < K; i++) r_entry[i] <= '0;
    end else if (w_in_acc) begin
      if (w_ins) begin
        for (int i = 0; i < K; i++) r_entry[i] <= w_ins_bank[i];
        if (r_fill < CW'(K)) r_fill <= r_fill + CW'(1);
      end
    end else if (w_out_xfer) begin
      if (w_last_rank) begin
        r_fill   <= '0;
        r_rd_idx <= '0;
        for (int i = 0; i < K; i++) r_entry[i] <= '0;
      end else begin
        r_rd_idx <= r_rd_idx + CW'(1);
      end
    end
  end

  assign in_ready  = (r_state == ST_COLLECT);
  assign out_valid = (r_state == ST_DRAIN);
  assign out_data  = out_valid ? r_entry[r_rd_idx[IW-1:0]] : '0;
  assign out_rank  = out_valid ? r_rd_idx[IW-1:0] : '0;
  assign out_last  = out_valid && w_last_rank;

endmodule

// File: doc/topk_frame_drain.md
Name: topk_frame_drain

Overview:
- Frame-based top-K collector and reader for sample streams.
- Accepts a framed input stream (valid/ready/last) and keeps the K largest unsigned samples of the current frame in a sorted register bank.
- After the frame's last beat, drains the collected values in descending order over a valid/ready output stream, then clears and re-arms.
- Serves as the readout end of the running-maximum tracking path: downstream logic consumes ranked results per frame instead of sampling a free-running tracker.

Parameters:
- DATA_WIDTH, 32, sample width in bits, unsigned compare.
- K, 4, number of ranked entries kept; legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  DATA_WIDTH  input sample.
- in_last  input  1  marks the final sample of the frame; qualified by in_valid.
- out_valid  output  1  ranked value available.
- out_ready  input  1  downstream accepts the ranked value.
- out_data  output  DATA_WIDTH  ranked value; rank 0 (largest) first.
- out_last  output  1  marks the final ranked value of the frame.
- out_rank  output  $clog2(K)  rank index of out_data, 0 = largest.

Behaviour:
- Reset: async assert clears everything. State = COLLECT, fill = 0, all entries = 0, out_valid = 0, out_last = 0, out_data = 0, out_rank = 0, in_ready = 1.
- Input accept: an input beat is accepted when in_valid && in_ready.
- States: COLLECT (in_ready = 1, out_valid = 0) and DRAIN (in_ready = 0, out_valid = 1).
- Insertion in COLLECT: each accepted sample is inserted into the bank, which stays sorted descending.
  - Insertion position = first entry strictly less than in_data, among filled entries.
  - Lower entries shift down by one; the entry at index K-1 is discarded when the bank is full.
  - If no filled entry is smaller and fill < K, the sample goes to index fill.
  - If no filled entry is smaller and fill == K, the sample is discarded.
  - Ties are stable: a new value equal to an existing one lands below it.
  - fill saturates at K.
- Latency: the bank reflects an accepted sample on the next edge (1 cycle).
- Frame end: an accepted beat with in_last = 1 is inserted like any other. On the same edge, state goes to DRAIN, so out_valid = 1 in the following cycle.
- DRAIN outputs: out_data = entry[rd_idx], out_rank = rd_idx, out_last = (rd_idx == fill-1).
  - rd_idx starts at 0.
  - Only filled entries are output, so a frame shorter than K drains only its sample count.
- Output handshake: a beat transfers when out_valid && out_ready; rd_idx then increments.
  - Holding out_ready low stalls indefinitely. out_data, out_rank and out_last must stay stable while stalled.
- Drain end: a transfer with out_last = 1 causes, on the same edge, state = COLLECT, fill = 0, all entries cleared, rd_idx = 0. in_ready = 1 next cycle.
  - No overlap: input is back-pressured for the whole drain.
- in_last without in_valid is ignored.
- Reset mid-frame or mid-drain aborts immediately. No partial output and no residual entries remain.
- Widths: rd_idx and fill are sized $clog2(K+1). Compare is unsigned, full DATA_WIDTH.
- Invariants (verification targets):
  - entry[i] >= entry[i+1] for all filled i.
  - fill <= K.
  - out_valid implies state == DRAIN.
  - in_ready == (state == COLLECT).

Optional Feature:
- Macro: TOPK_DEDUP_EN.
- Defined: an accepted sample equal to any filled entry is dropped.
  - The bank and fill are unchanged.
  - in_last still ends the frame.
  - Drained values are then strictly descending.
- Undefined: duplicates are kept per the stable-tie rule above.

Test Plan:
- Reset defaults: hold resetn = 0 -> in_ready = 1, out_valid = 0, out_data = 0. Release with no input -> outputs unchanged.
- Basic frame, K = 4, out_ready = 1: frame 5, 9, 1, 7, 3 (last on 3) -> out_valid the cycle after the last beat. Drains 9, 7, 5, 3 with ranks 0..3; out_last on 3. in_ready returns 1 the cycle after.
- Short frame with back-pressure: frame 42 (last), out_ready = 0 for 3 cycles -> out_data = 42 stable with out_last = 1, out_rank = 0. Single transfer when out_ready rises, then back to COLLECT.
- Ties and saturation: frame 8, 8, 8, 8, 8, 2 (last) -> drains 8, 8, 8, 8 and 2 is discarded. With TOPK_DEDUP_EN -> drains 8, 2.
- Reset mid-drain: after draining 9 and 7 from the basic frame, pulse resetn low -> out_valid = 0 immediately. A new frame 1 (last) drains only 1.
- Back-to-back frames: drive in_valid continuously through a drain -> no input accepted while out_valid = 1. The second frame's results contain no values from the first.
